fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- F stage plus F/D pipeline register of the P5 five-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Latches {instr, pc} into D for the decoder and immediate extender.
- Consumes the D-stage redirect: branch target built from the sign-extended 32-bit offset produced in D, j target, jr register target.
- Delay slot is architected: the instruction after a branch/jump always executes.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_WORDS, 4096, instruction-memory depth in words; PC outside [IM_BASE, IM_BASE+4*IM_WORDS) fetches a nop.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes PC and F/D register.
- br_taken  in  1  D-stage branch resolved taken.
- br_offset32  in  32  sign-extended branch offset from D-stage extender (word offset).
- j_en  in  1  D-stage j/jal.
- j_index  in  26  instr[25:0] of the D-stage jump.
- jr_en  in  1  D-stage jr/jalr.
- jr_target  in  32  forwarded rs value for jr.
- imem_addr  out  12  word index into instruction memory, (F_pc-IM_BASE)>>2.
- imem_rdata  in  32  combinational instruction-memory read data.
- F_pc  out  32  current fetch PC.
- D_instr  out  32  F/D instruction.
- D_pc  out  32  F/D PC.
- D_valid  out  1  F/D holds a real fetched instruction (0 after reset/flush).

Behaviour:
- Reset (async, any cycle): F_pc=PC_RESET, D_instr=0, D_pc=0, D_valid=0; any in-flight redirect is discarded.
- Per rising edge, stall=0:
  - D_instr <= fetched word; D_pc <= F_pc; D_valid <= 1.
  - F_pc <= next_pc.
- Per rising edge, stall=1:
  - F_pc, D_instr, D_pc, D_valid all hold.
  - Redirect inputs are ignored; the hazard unit re-presents them once the stall clears.
- next_pc priority (combinational):
  - jr_en: jr_target.
  - else j_en: {D_pc+4 [31:28], j_index, 2'b00}.
  - else br_taken: D_pc + 4 + (br_offset32 << 2), 32-bit wrap-around arithmetic, carry discarded.
  - else F_pc + 4.
- More than one redirect asserted together is a decode error; the priority above still applies deterministically.
- Redirect qualification: honoured only when D_valid=1. With D_valid=0, redirects are ignored and next_pc = F_pc+4.
- Fetch word:
  - imem_rdata when F_pc is in range and F_pc[1:0]==0.
  - Otherwise 32'h0000_0000 (nop).
  - The PC still advances normally; no exception is raised in P5.
- imem_addr = (F_pc-IM_BASE)[13:2]. Only meaningful in range; out-of-range values are don't-care because the data is replaced.
- Latency:
  - Fetch to D: 1 cycle.
  - Redirect: takes effect at the next edge. The delay-slot instruction already in F is latched into D normally.
- jr_target with nonzero [1:0] is loaded as-is; the next fetch then yields a nop per the rule above.

Optional Feature:
- Macro: NO_DELAY_SLOT_EN.
- Defined: on an accepted redirect (stall=0, D_valid=1, any of jr_en/j_en/br_taken), the F/D register loads D_instr=0 and D_valid=0 instead of the delay-slot word. D_pc still loads F_pc. This is used for the non-delay-slot variant of the course tests.
- Undefined: no flush; architected delay slot as above.

Decomposition:
- Shared package holds:
  - PC_RESET, IM_BASE, IM_WORDS.
  - NOP = 32'h0.
  - Redirect-select enum {SEQ, BR, J, JR}, also used by the D-stage control decoder.
- One natural sub-module, fd_reg: the F/D register with stall, optional flush and async reset.
- The PC register and next_pc mux stay in fetch_stage.

Test Plan:
- Reset then 3 free-running cycles, stall=0, imem word k = 32'h1000_0000+k:
  - F_pc = 3000, 3004, 3008, 300C.
  - D_instr follows one cycle later.
  - D_valid is 0 then 1.
- Backward branch: D_pc=3008, br_taken=1, br_offset32=32'hFFFF_FFFE.
  - Next F_pc = 3004.
  - The delay slot (pc 300C) appears in D.
  - With NO_DELAY_SLOT_EN, D_instr=0 and D_valid=0 instead.
- Jumps:
  - j with D_pc=3010, j_index=26'h0000C08: next F_pc = 0000_3020.
  - jr_en with jr_target=3040, asserted together with br_taken: next F_pc = 3040 (jr wins).
- stall=1 for 2 cycles with br_taken=1:
  - F_pc, D_instr and D_valid hold.
  - Release with br_taken still 1: redirect is taken on the release edge.
- F_pc = IM_BASE+4*IM_WORDS (jr there): D_instr=0, and the PC continues +4.
- Async reset asserted mid-cycle between edges with a pending branch:
  - Outputs go to reset values immediately.
  - First post-reset fetch is at 3000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants and types shared by the fetch stage and
// the D-stage control decoder.
//   PC_RESET / IM_BASE / IM_WORDS : reset PC and instruction-memory window
//   NOP                           : word substituted for unfetchable PCs
//   redir_sel_e                   : next-PC source select {SEQ, BR, J, JR}
//   pc_fetchable()                : PC is inside the window and word aligned
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;
  localparam logic [31:0] IM_END   = IM_BASE + 32'(4 * IM_WORDS);
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    J   = 2'd2,
    JR  = 2'd3
  } redir_sel_e;

  function automatic logic pc_fetchable(input logic [31:0] pc);
    return (pc >= IM_BASE) && (pc < IM_END) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundle of hazard/redirect inputs, instruction-memory
// port and F/D outputs of the fetch stage.
//   master : environment side (hazard unit, D stage, instruction memory)
//   slave  : fetch_stage side
interface fetch_stage_if;

  logic        stall;
  logic        br_taken;
  logic [31:0] br_offset32;
  logic        j_en;
  logic [25:0] j_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] F_pc;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic        D_valid;

  modport master (
    output stall, br_taken, br_offset32, j_en, j_index, jr_en, jr_target,
    output imem_rdata,
    input  imem_addr, F_pc, D_instr, D_pc, D_valid
  );

  modport slave (
    input  stall, br_taken, br_offset32, j_en, j_index, jr_en, jr_target,
    input  imem_rdata,
    output imem_addr, F_pc, D_instr, D_pc, D_valid
  );

endinterface

// File: rtl/fetch_stage_fd_reg.sv
// fetch_stage_fd_reg: F/D pipeline register.
//   clk, reset : rising-edge clock, async active-high reset
//   i_stall    : hold all contents
//   i_flush    : load a bubble (NOP, valid=0) instead of i_instr; pc still loads
//   i_instr    : fetched word
//   i_pc       : PC of the fetched word
//   o_instr / o_pc / o_valid : D-stage instruction, PC and valid flag
module fetch_stage_fd_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);
  import fetch_stage_pkg::*;

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= NOP;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      r_instr <= i_flush ? NOP : i_instr;
      r_pc    <= i_pc;
      r_valid <= !i_flush;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: F stage (PC register, next-PC mux, instruction-memory
// address) plus the F/D register of the five-stage MIPS pipeline.
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : fetch_stage_if.slave (stall, redirects, imem port, F_pc, D_*)
// Build option: NO_DELAY_SLOT_EN -- when defined, an accepted redirect turns
// the delay-slot word into a bubble in D; otherwise the delay slot executes.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_fetch_word;
  logic [31:0] w_im_off;
  logic [31:0] w_dpc4;
  logic [31:0] w_br_target;
  logic        w_flush;
  logic        w_unused;
  redir_sel_e  w_sel;

  // Redirects come from D and only mean something when D holds a real instr.
  always_comb begin
    w_sel = SEQ;
    if (bus.D_valid) begin
      if (bus.jr_en)         w_sel = JR;
      else if (bus.j_en)     w_sel = J;
      else if (bus.br_taken) w_sel = BR;
    end
  end

  assign w_dpc4      = bus.D_pc + 32'd4;
  assign w_br_target = w_dpc4 + {bus.br_offset32[29:0], 2'b00};

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    case (w_sel)
      JR:      w_next_pc = bus.jr_target;
      J:       w_next_pc = {w_dpc4[31:28], bus.j_index, 2'b00};
      BR:      w_next_pc = w_br_target;
      default: w_next_pc = r_pc + 32'd4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_pc <= PC_RESET;
    else if (!bus.stall) r_pc <= w_next_pc;
  end

  assign w_im_off      = r_pc - IM_BASE;
  assign bus.imem_addr = w_im_off[13:2];
  // Out-of-window or misaligned PCs fetch a nop; the PC keeps advancing.
  assign w_fetch_word  = pc_fetchable(r_pc) ? bus.imem_rdata : NOP;
  assign bus.F_pc      = r_pc;

`ifdef NO_DELAY_SLOT_EN
  assign w_flush = !bus.stall && (w_sel != SEQ);
`else
  assign w_flush = 1'b0;
`endif

  assign w_unused = &{1'b0, w_im_off[31:14], w_im_off[1:0], bus.br_offset32[31:30]};

  fetch_stage_fd_reg u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .i_stall (bus.stall),
    .i_flush (w_flush),
    .i_instr (w_fetch_word),
    .i_pc    (r_pc),
    .o_instr (bus.D_instr),
    .o_pc    (bus.D_pc),
    .o_valid (bus.D_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] fpc;
    logic [31:0] dinstr;
    logic [31:0] dpc;
    logic        dvalid;
  } exp_t;

  logic clk;
  logic reset;
  fetch_stage_if bus();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [31:0] m_fpc, m_dinstr, m_dpc;
  logic        m_dvalid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word k holds 32'h1000_0000 + k.
  always_comb bus.imem_rdata = 32'h1000_0000 + {20'h0, bus.imem_addr};

  function automatic logic [31:0] ref_fetch(input logic [31:0] pc);
    if (pc >= 32'h3000 && pc < 32'h7000 && pc[1:0] == 2'b00)
      return 32'h1000_0000 + ((pc - 32'h3000) >> 2);
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_fpc    = 32'h3000;
    m_dinstr = 32'h0;
    m_dpc    = 32'h0;
    m_dvalid = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the post-edge state, and compare it
  // against the DUT one time unit after the edge.
  task automatic drive_cycle(input logic st, input logic br, input logic [31:0] off,
                             input logic jn, input logic [25:0] ji,
                             input logic jrn, input logic [31:0] jt);
    exp_t e;
    exp_t got;
    logic [31:0] npc;
    logic [31:0] dpc4;
    logic redir;
    bus.stall = st; bus.br_taken = br; bus.br_offset32 = off;
    bus.j_en = jn; bus.j_index = ji; bus.jr_en = jrn; bus.jr_target = jt;
    if (m_fpc >= 32'h3000 && m_fpc < 32'h7000) begin
      checks++;
      if (bus.imem_addr !== 12'((m_fpc - 32'h3000) >> 2)) begin
        errors++;
        $display("FAIL imem_addr: got %h want %h", bus.imem_addr, 12'((m_fpc - 32'h3000) >> 2));
      end
    end
    dpc4 = m_dpc + 32'd4;
    if (st) begin
      e = '{m_fpc, m_dinstr, m_dpc, m_dvalid};
    end else begin
      redir = m_dvalid && (jrn || jn || br);
      if (!m_dvalid)  npc = m_fpc + 32'd4;
      else if (jrn)   npc = jt;
      else if (jn)    npc = {dpc4[31:28], ji, 2'b00};
      else if (br)    npc = dpc4 + off * 32'd4;
      else            npc = m_fpc + 32'd4;
      e = '{npc, ref_fetch(m_fpc), m_fpc, 1'b1};
`ifdef NO_DELAY_SLOT_EN
      if (redir) begin e.dinstr = 32'h0; e.dvalid = 1'b0; end
`else
      if (redir) e.dvalid = 1'b1;
`endif
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      got = '{bus.F_pc, bus.D_instr, bus.D_pc, bus.D_valid};
      if (got !== e) begin
        errors++;
        $display("FAIL sb_state: got F_pc=%h D_instr=%h D_pc=%h D_valid=%b want F_pc=%h D_instr=%h D_pc=%h D_valid=%b",
                 got.fpc, got.dinstr, got.dpc, got.dvalid, e.fpc, e.dinstr, e.dpc, e.dvalid);
      end
      m_fpc = e.fpc; m_dinstr = e.dinstr; m_dpc = e.dpc; m_dvalid = e.dvalid;
    end
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_offset32 = 32'h0;
    bus.j_en = 1'b0; bus.j_index = 26'h0; bus.jr_en = 1'b0; bus.jr_target = 32'h0;
    model_reset();
    #12;
    checks++;
    if ({bus.F_pc, bus.D_instr, bus.D_pc, bus.D_valid} !== {32'h3000, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got F_pc=%h D_instr=%h D_pc=%h D_valid=%b want 3000/0/0/0",
               bus.F_pc, bus.D_instr, bus.D_pc, bus.D_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    idle();
    checks++;
    if (bus.F_pc !== 32'h3004 || bus.D_instr !== 32'h1000_0000 || bus.D_valid !== 1'b1) begin
      errors++;
      $display("FAIL free_run_1: got F_pc=%h D_instr=%h D_valid=%b want 3004/10000000/1",
               bus.F_pc, bus.D_instr, bus.D_valid);
    end
    idle();
    idle();
    checks++;
    if (bus.F_pc !== 32'h300C || bus.D_instr !== 32'h1000_0002 || bus.D_pc !== 32'h3008) begin
      errors++;
      $display("FAIL free_run_3: got F_pc=%h D_instr=%h D_pc=%h want 300c/10000002/3008",
               bus.F_pc, bus.D_instr, bus.D_pc);
    end
  endtask

  task automatic test_branch();
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    checks++;
`ifdef NO_DELAY_SLOT_EN
    if (bus.F_pc !== 32'h3004 || bus.D_pc !== 32'h300C || bus.D_instr !== 32'h0 || bus.D_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_branch: got F_pc=%h D_pc=%h D_instr=%h D_valid=%b want 3004/300c/0/0",
               bus.F_pc, bus.D_pc, bus.D_instr, bus.D_valid);
    end
`else
    if (bus.F_pc !== 32'h3004 || bus.D_pc !== 32'h300C || bus.D_instr !== 32'h1000_0003 || bus.D_valid !== 1'b1) begin
      errors++;
      $display("FAIL back_branch: got F_pc=%h D_pc=%h D_instr=%h D_valid=%b want 3004/300c/10000003/1",
               bus.F_pc, bus.D_pc, bus.D_instr, bus.D_valid);
    end
`endif
  endtask

  task automatic test_jumps();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h3010);
    idle();
    checks++;
    if (bus.D_pc !== 32'h3010) begin
      errors++;
      $display("FAIL j_setup: got D_pc=%h want 3010", bus.D_pc);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 26'h0000C08, 1'b0, 32'h0);
    checks++;
    if (bus.F_pc !== 32'h3020) begin
      errors++;
      $display("FAIL j_target: got F_pc=%h want 3020", bus.F_pc);
    end
    idle();
    drive_cycle(1'b0, 1'b1, 32'h0000_0010, 1'b0, 26'h0, 1'b1, 32'h3040);
    checks++;
    if (bus.F_pc !== 32'h3040) begin
      errors++;
      $display("FAIL jr_priority: got F_pc=%h want 3040", bus.F_pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_instr;
    idle();
    h_instr = bus.D_instr;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 32'h0000_0004, 1'b0, 26'h0, 1'b0, 32'h0);
      checks++;
      if (bus.F_pc !== 32'h3044 || bus.D_instr !== h_instr || bus.D_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got F_pc=%h D_instr=%h D_valid=%b want 3044/%h/1",
                 bus.F_pc, bus.D_instr, bus.D_valid, h_instr);
      end
    end
    drive_cycle(1'b0, 1'b1, 32'h0000_0004, 1'b0, 26'h0, 1'b0, 32'h0);
    checks++;
    if (bus.F_pc !== 32'h3054) begin
      errors++;
      $display("FAIL stall_release: got F_pc=%h want 3054", bus.F_pc);
    end
  endtask

  task automatic test_out_of_range();
    idle();
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h7000);
    idle();
    checks++;
    if (bus.D_instr !== 32'h0 || bus.D_pc !== 32'h7000 || bus.F_pc !== 32'h7004) begin
      errors++;
      $display("FAIL oob_fetch: got D_instr=%h D_pc=%h F_pc=%h want 0/7000/7004",
               bus.D_instr, bus.D_pc, bus.F_pc);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h3002);
    idle();
    checks++;
    if (bus.D_instr !== 32'h0 || bus.F_pc !== 32'h3006) begin
      errors++;
      $display("FAIL misaligned_fetch: got D_instr=%h F_pc=%h want 0/3006", bus.D_instr, bus.F_pc);
    end
    idle();
  endtask

  task automatic test_async_reset();
    bus.stall = 1'b0; bus.br_taken = 1'b1; bus.br_offset32 = 32'h0000_0040;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.F_pc, bus.D_instr, bus.D_pc, bus.D_valid} !== {32'h3000, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got F_pc=%h D_instr=%h D_pc=%h D_valid=%b want 3000/0/0/0",
               bus.F_pc, bus.D_instr, bus.D_pc, bus.D_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive_cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0, 26'h0, 1'b0, 32'h0);
    checks++;
    if (bus.F_pc !== 32'h3004 || bus.D_pc !== 32'h3000 || bus.D_instr !== 32'h1000_0000) begin
      errors++;
      $display("FAIL post_reset_fetch: got F_pc=%h D_pc=%h D_instr=%h want 3004/3000/10000000",
               bus.F_pc, bus.D_pc, bus.D_instr);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_jumps();
    test_stall();
    test_out_of_range();
    test_async_reset();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
